shifter_result_stage: RTL and testbench
=======================================

// Module: shifter_result_stage
//
// PURPOSE
//  Registered output stage directly downstream of the combinational Shifter.
//  - Captures each Shifter result/carryOut pair into a 2-entry buffer with valid/ready handshaking.
//  - Computes zero and negative flags at capture time.
//  - Holds a chained carry register that drives the Shifter carryIn, for multi-word shifts.
//  - Decouples the combinational shift path from the ALU writeback consumer.
//
// PARAMETERS
//  DataLength  4  width of result data; must match the Shifter DataLength (>= 2)
//
// PORTS
//  clock        in   1           rising-edge clock; the single clock of the block
//  reset        in   1           asynchronous, active-high reset
//  inValid      in   1           Shifter result on inResult/inCarry/inControl is valid
//  inReady      out  1           stage can accept an entry this cycle
//  inResult     in   DataLength  Shifter result
//  inCarry      in   1           Shifter carryOut
//  inControl    in   2           shift op code that produced the result (00 LSL, 01 LSR, 10 ASR, 11 ASL)
//  outValid     out  1           head entry valid
//  outReady     in   1           consumer accepts the head entry
//  outResult    out  DataLength  head entry result
//  outCarry     out  1           head entry carry
//  outZero      out  1           head entry result == 0
//  outNegative  out  1           head entry result MSB
//  outControl   out  2           head entry op code
//  carryChain   out  1           registered carry; wire to Shifter carryIn
//  clearCarry   in   1           synchronous clear of carryChain
//  occupancy    out  2           number of buffered entries (0..2)
//
// BEHAVIOUR
//  - Reset (async, any time, including mid-transfer):
//    - occupancy=0, outValid=0, inReady=1 after reset asserts; buffered entries are discarded.
//    - carryChain=0; outResult/outCarry/outZero/outNegative/outControl=0.
//  - Storage: 2-entry FIFO (entries 0/1 with head pointer, or head+skid register). Each entry holds
//    {result, carry, zero, negative, control}.
//  - Flag computation on enqueue:
//    - zero = (inResult == 0).
//    - negative = inResult[DataLength-1].
//    - Flags are stored with the entry and never recomputed.
//  - Handshakes:
//    - enq = inValid & inReady; deq = outValid & outReady.
//    - inReady = (occupancy != 2); depends only on state, never on inValid or outReady.
//    - outValid = (occupancy != 0); out* show the head entry and are stable while outValid & !outReady.
//    - Inputs are sampled only on enq; inResult may change freely otherwise.
//  - Latency:
//    - An entry accepted in cycle N is visible on out* at cycle N+1.
//    - No combinational bypass from in* to out*.
//  - Occupancy update:
//    - enq only: occupancy+1; deq only: occupancy-1; enq and deq: unchanged.
//    - occupancy 1 with enq & deq: the new entry becomes head next cycle.
//    - occupancy 2: enq is impossible because inReady=0; deq takes it to 1 and inReady=1 the next cycle.
//    - occupancy 0: deq is impossible because outValid=0; outReady is ignored.
//  - carryChain:
//    - On deq, loads the dequeued entry's carry.
//    - clearCarry forces 0 next cycle.
//    - If clearCarry and deq occur together, clear wins.
//    - Otherwise carryChain holds its value.
//  - Order preserved strictly FIFO; no entry dropped or duplicated.
//  - inValid asserted at occupancy 2 is held off and not lost; the source must hold data until inReady.
//
// TESTING
//  1. reset asserted mid-stream with occupancy=2 -> same cycle: outValid=0, occupancy=0, carryChain=0;
//     after release: inReady=1.
//  2. enq inResult=4'b0000, inCarry=1, inControl=01, outReady=1 -> next cycle: outValid=1, outZero=1,
//     outNegative=0, outCarry=1, outControl=01; cycle after: carryChain=1, occupancy=0.
//  3. outReady=0; enq 4'b1010 then 4'b0011 -> occupancy=2, inReady=0; a third enq 4'b0101 held off;
//     outReady=1 -> outputs 1010 (N=1), 0011 (N=0), 0101 in order.
//  4. occupancy=1 (head 0110), simultaneous enq 1001 and deq -> next cycle occupancy=1, outResult=1001,
//     outNegative=1.
//  5. carryChain=1; deq of an entry with carry=1 in the same cycle as clearCarry=1 -> next cycle carryChain=0.
//  6. random inValid/outReady, 1000 transfers, DataLength=8 -> scoreboard order and flags match;
//     occupancy never exceeds 2; out* stable under backpressure.

Source files
------------

// File: rtl/shifter_result_stage_if.sv
// Handshake and result bus between the Shifter and its registered output stage.
// The master side (Shifter/consumer environment) drives data in and accepts results out.
interface shifter_result_stage_if #(parameter int DataLength = 4);
    logic                  inValid;
    logic                  inReady;
    logic [DataLength-1:0] inResult;
    logic                  inCarry;
    logic [1:0]            inControl;
    logic                  outValid;
    logic                  outReady;
    logic [DataLength-1:0] outResult;
    logic                  outCarry;
    logic                  outZero;
    logic                  outNegative;
    logic [1:0]            outControl;
    logic                  carryChain;
    logic                  clearCarry;
    logic [1:0]            occupancy;

    modport master (
        output inValid, inResult, inCarry, inControl, outReady, clearCarry,
        input  inReady, outValid, outResult, outCarry, outZero, outNegative,
               outControl, carryChain, occupancy
    );

    modport slave (
        input  inValid, inResult, inCarry, inControl, outReady, clearCarry,
        output inReady, outValid, outResult, outCarry, outZero, outNegative,
               outControl, carryChain, occupancy
    );
endinterface

// File: rtl/shifter_result_stage.sv
// Registered 2-entry output buffer behind the combinational Shifter: captures result,
// carry and op code with precomputed zero/negative flags, and keeps the chained carry.
module shifter_result_stage #(
    parameter int DataLength = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    shifter_result_stage_if.slave  bus
);

    typedef struct packed {
        logic [DataLength-1:0] result;
        logic                  carry;
        logic                  zero;
        logic                  negative;
        logic [1:0]            control;
    } entry_t;

    entry_t     entries [2];
    entry_t     newEntry;
    entry_t     headEntry;
    logic       head;
    logic       writePtr;
    logic [1:0] occupancy;
    logic       carryReg;
    logic       enq;
    logic       deq;

    assign bus.inReady  = (occupancy != 2'd2);
    assign bus.outValid = (occupancy != 2'd0);
    assign enq          = bus.inValid & bus.inReady;
    assign deq          = bus.outValid & bus.outReady;

    // The free slot is the one after the head when an entry is already buffered.
    assign writePtr = head ^ occupancy[0];

    // Flags are fixed at capture so the consumer never sees them recomputed.
    always_comb begin
        newEntry          = '0;
        newEntry.result   = bus.inResult;
        newEntry.carry    = bus.inCarry;
        newEntry.zero     = (bus.inResult == '0);
        newEntry.negative = bus.inResult[DataLength-1];
        newEntry.control  = bus.inControl;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entries[0] <= '0;
            entries[1] <= '0;
            head       <= 1'b0;
            occupancy  <= 2'd0;
            carryReg   <= 1'b0;
        end else begin
            if (enq) begin
                entries[writePtr] <= newEntry;
            end
            if (deq) begin
                head <= ~head;
            end
            case ({enq, deq})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
            // A clear request outranks loading the carry of the entry leaving this cycle.
            if (bus.clearCarry) begin
                carryReg <= 1'b0;
            end else if (deq) begin
                carryReg <= entries[head].carry;
            end
        end
    end

    always_comb begin
        headEntry = '0;
        if (bus.outValid) begin
            headEntry = entries[head];
        end
    end

    assign bus.outResult   = headEntry.result;
    assign bus.outCarry    = headEntry.carry;
    assign bus.outZero     = headEntry.zero;
    assign bus.outNegative = headEntry.negative;
    assign bus.outControl  = headEntry.control;
    assign bus.carryChain  = carryReg;
    assign bus.occupancy   = occupancy;

endmodule

// File: tb/tb_shifter_result_stage.sv
// Directed vector table on a 4-bit stage, hand sequences for reset, and a randomized
// scoreboard run on an 8-bit stage.
module tb_shifter_result_stage;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    shifter_result_stage_if #(.DataLength(4)) busA ();
    shifter_result_stage_if #(.DataLength(8)) busB ();

    shifter_result_stage #(.DataLength(4)) dutA (.clock(clock), .reset(reset), .bus(busA.slave));
    shifter_result_stage #(.DataLength(8)) dutB (.clock(clock), .reset(reset), .bus(busB.slave));

    typedef struct {
        logic       inValid;
        logic [3:0] inResult;
        logic       inCarry;
        logic [1:0] inControl;
        logic       outReady;
        logic       clearCarry;
        logic       expValid;
        logic [3:0] expResult;
        logic       expZero;
        logic       expNeg;
        logic       expCarry;
        logic [1:0] expControl;
        logic [1:0] expOcc;
        logic       expChain;
        logic       expInReady;
    } vec_t;

    typedef struct {
        logic [7:0] result;
        logic       carry;
        logic [1:0] control;
    } sb_t;

    vec_t vectors [17];
    sb_t  sb [$];

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        busA.inValid    = v.inValid;
        busA.inResult   = v.inResult;
        busA.inCarry    = v.inCarry;
        busA.inControl  = v.inControl;
        busA.outReady   = v.outReady;
        busA.clearCarry = v.clearCarry;
    endtask

    initial begin
        busA.inValid = 0; busA.inResult = '0; busA.inCarry = 0; busA.inControl = '0;
        busA.outReady = 0; busA.clearCarry = 0;
        busB.inValid = 0; busB.inResult = '0; busB.inCarry = 0; busB.inControl = '0;
        busB.outReady = 0; busB.clearCarry = 0;

        //              iv res     c ctl    or clr  ev eres    z  n  c ectl   occ   ch ir
        vectors[0]  = '{1, 4'b0000, 1, 2'b01, 1, 0, 1, 4'b0000, 1, 0, 1, 2'b01, 2'd1, 0, 1};
        vectors[1]  = '{0, 4'b0000, 0, 2'b00, 1, 0, 0, 4'b0000, 0, 0, 0, 2'b00, 2'd0, 1, 1};
        vectors[2]  = '{1, 4'b1010, 0, 2'b10, 0, 0, 1, 4'b1010, 0, 1, 0, 2'b10, 2'd1, 1, 1};
        vectors[3]  = '{1, 4'b0011, 1, 2'b00, 0, 0, 1, 4'b1010, 0, 1, 0, 2'b10, 2'd2, 1, 0};
        vectors[4]  = '{1, 4'b0101, 0, 2'b11, 0, 0, 1, 4'b1010, 0, 1, 0, 2'b10, 2'd2, 1, 0};
        vectors[5]  = '{1, 4'b0101, 0, 2'b11, 1, 0, 1, 4'b0011, 0, 0, 1, 2'b00, 2'd1, 0, 1};
        vectors[6]  = '{1, 4'b0101, 0, 2'b11, 1, 0, 1, 4'b0101, 0, 0, 0, 2'b11, 2'd1, 1, 1};
        vectors[7]  = '{0, 4'b0000, 0, 2'b00, 1, 0, 0, 4'b0000, 0, 0, 0, 2'b00, 2'd0, 0, 1};
        vectors[8]  = '{1, 4'b0110, 1, 2'b00, 0, 0, 1, 4'b0110, 0, 0, 1, 2'b00, 2'd1, 0, 1};
        vectors[9]  = '{1, 4'b1001, 1, 2'b10, 1, 0, 1, 4'b1001, 0, 1, 1, 2'b10, 2'd1, 1, 1};
        vectors[10] = '{0, 4'b0000, 0, 2'b00, 1, 1, 0, 4'b0000, 0, 0, 0, 2'b00, 2'd0, 0, 1};
        vectors[11] = '{1, 4'b1111, 0, 2'b11, 0, 0, 1, 4'b1111, 0, 1, 0, 2'b11, 2'd1, 0, 1};
        vectors[12] = '{0, 4'b0000, 0, 2'b00, 1, 0, 0, 4'b0000, 0, 0, 0, 2'b00, 2'd0, 0, 1};
        vectors[13] = '{1, 4'b1100, 1, 2'b01, 0, 0, 1, 4'b1100, 0, 1, 1, 2'b01, 2'd1, 0, 1};
        vectors[14] = '{0, 4'b0000, 0, 2'b00, 1, 0, 0, 4'b0000, 0, 0, 0, 2'b00, 2'd0, 1, 1};
        vectors[15] = '{0, 4'b0000, 0, 2'b00, 0, 0, 0, 4'b0000, 0, 0, 0, 2'b00, 2'd0, 1, 1};
        vectors[16] = '{0, 4'b0000, 0, 2'b00, 0, 1, 0, 4'b0000, 0, 0, 0, 2'b00, 2'd0, 0, 1};

        repeat (2) @(negedge clock);
        checkOutput("reset.outValid", busA.outValid, 0);
        checkOutput("reset.occupancy", busA.occupancy, 0);
        checkOutput("reset.carryChain", busA.carryChain, 0);
        checkOutput("reset.inReady", busA.inReady, 1);
        checkOutput("reset.outResult", busA.outResult, 0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            applyStimulus(vectors[i]);
            @(posedge clock);
            #1;
            checkOutput($sformatf("row%0d.outValid", i), busA.outValid, vectors[i].expValid);
            checkOutput($sformatf("row%0d.occupancy", i), busA.occupancy, vectors[i].expOcc);
            checkOutput($sformatf("row%0d.carryChain", i), busA.carryChain, vectors[i].expChain);
            checkOutput($sformatf("row%0d.inReady", i), busA.inReady, vectors[i].expInReady);
            if (vectors[i].expValid) begin
                checkOutput($sformatf("row%0d.outResult", i), busA.outResult, vectors[i].expResult);
                checkOutput($sformatf("row%0d.outZero", i), busA.outZero, vectors[i].expZero);
                checkOutput($sformatf("row%0d.outNegative", i), busA.outNegative, vectors[i].expNeg);
                checkOutput($sformatf("row%0d.outCarry", i), busA.outCarry, vectors[i].expCarry);
                checkOutput($sformatf("row%0d.outControl", i), busA.outControl, vectors[i].expControl);
            end
        end

        // Build occupancy 2 with carryChain set, then hit reset between clock edges.
        @(negedge clock);
        busA.clearCarry = 0; busA.outReady = 0;
        busA.inValid = 1; busA.inResult = 4'b1000; busA.inCarry = 1; busA.inControl = 2'b10;
        @(negedge clock);
        busA.inValid = 0; busA.outReady = 1;
        @(negedge clock);
        busA.outReady = 0; busA.inValid = 1; busA.inResult = 4'b0001; busA.inCarry = 1;
        @(negedge clock);
        busA.inResult = 4'b0010;
        @(negedge clock);
        busA.inValid = 0;
        checkOutput("midreset.preOccupancy", busA.occupancy, 2);
        checkOutput("midreset.preCarryChain", busA.carryChain, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset.outValid", busA.outValid, 0);
        checkOutput("midreset.occupancy", busA.occupancy, 0);
        checkOutput("midreset.carryChain", busA.carryChain, 0);
        checkOutput("midreset.outResult", busA.outResult, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("postreset.inReady", busA.inReady, 1);
        checkOutput("postreset.occupancy", busA.occupancy, 0);

        begin
            int   transfers = 0;
            int   cycles = 0;
            logic holding = 0;
            logic modelChain = 0;
            logic prevStall = 0;
            logic [7:0] prevResult = '0;
            logic enq;
            logic deq;
            sb_t  item;
            while (transfers < 1000 && cycles < 20000) begin
                @(negedge clock);
                cycles++;
                checkOutput("rand.occupancy", busB.occupancy, sb.size());
                checkOutput("rand.outValid", busB.outValid, sb.size() != 0);
                checkOutput("rand.inReady", busB.inReady, sb.size() != 2);
                checkOutput("rand.carryChain", busB.carryChain, modelChain);
                if (busB.occupancy > 2'd2) checkOutput("rand.occupancyBound", busB.occupancy, 2);
                if (sb.size() != 0) begin
                    checkOutput("rand.outResult", busB.outResult, sb[0].result);
                    checkOutput("rand.outCarry", busB.outCarry, sb[0].carry);
                    checkOutput("rand.outControl", busB.outControl, sb[0].control);
                    checkOutput("rand.outZero", busB.outZero, sb[0].result == 8'd0);
                    checkOutput("rand.outNegative", busB.outNegative, sb[0].result[7]);
                end
                if (prevStall) checkOutput("rand.stable", busB.outResult, prevResult);

                if (!holding && $urandom_range(0, 9) < 6) begin
                    busB.inValid   = 1;
                    busB.inResult  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
                    busB.inCarry   = 1'($urandom);
                    busB.inControl = 2'($urandom);
                    holding = 1;
                end else if (!holding) begin
                    busB.inValid = 0;
                end
                busB.outReady   = ($urandom_range(0, 3) != 0);
                busB.clearCarry = ($urandom_range(0, 15) == 0);

                enq = busB.inValid & (sb.size() != 2);
                deq = busB.outReady & (sb.size() != 0);
                prevStall  = (sb.size() != 0) && !busB.outReady;
                prevResult = busB.outResult;
                if (deq) begin
                    modelChain = sb[0].carry;
                    void'(sb.pop_front());
                    transfers++;
                end
                if (busB.clearCarry) modelChain = 0;
                if (enq) begin
                    item.result  = busB.inResult;
                    item.carry   = busB.inCarry;
                    item.control = busB.inControl;
                    sb.push_back(item);
                    holding = 0;
                    busB.inValid = 1;
                end
            end
            checkOutput("rand.transfersDone", transfers >= 1000, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
